register_file_responder: RTL and testbench

//  Responder end of the register-file port protocol: a WIDTH x 2^ADDR_BITS register file.

---
 rtl/register_file_responder.sv | 130 +++++++++++++
 tb/tb_register_file_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/register_file_responder.sv
// Register file responder: one write port, two registered read ports, register 0 reads as zero,
// zeroing sweep after reset. Define REGFILE_WRITE_BYPASS_EN to forward same-cycle writes to reads.
module register_file_responder #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 WrEn,
    input  logic [ADDR_BITS-1:0] Aw,
    input  logic [WIDTH-1:0]     Dw,
    input  logic                 RdEn,
    input  logic [ADDR_BITS-1:0] Aa,
    input  logic [ADDR_BITS-1:0] Ab,
    output logic [WIDTH-1:0]     Da,
    output logic [WIDTH-1:0]     Db,
    output logic                 rdValid,
    output logic                 ready
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]   r_sweep_cnt;
    logic [WIDTH-1:0]       r_mem [DEPTH];

    logic                   w_run;
    logic                   w_wr_en;
    logic [ADDR_BITS-1:0]   w_wr_addr;
    logic [WIDTH-1:0]       w_wr_data;
    logic                   w_user_wr;
    logic [WIDTH-1:0]       w_rd_a;
    logic [WIDTH-1:0]       w_rd_b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: INIT ends once the last address has been swept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_sweep_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        w_run = (r_state == ST_RUN);
        ready = w_run;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sweep_cnt <= ADDR_BITS'(1);
        end else if (r_state == ST_INIT) begin
            r_sweep_cnt <= r_sweep_cnt + ADDR_BITS'(1);
        end
    end

    // Single storage write port shared by the sweep and user writes; address 0 never written
    always_comb begin
        w_user_wr = w_run && WrEn && (Aw != '0);
        w_wr_en   = w_user_wr || !w_run;
        w_wr_addr = w_run ? Aw : r_sweep_cnt;
        w_wr_data = w_run ? Dw : '0;
    end

    // NOTE: storage has no reset branch so it maps to RAM; the INIT sweep does the clearing.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Read data selection: address 0 is constant zero, optional same-cycle forwarding
    always_comb begin
        if (Aa == '0) begin
            w_rd_a = '0;
        end else if (BYPASS && w_user_wr && (Aa == Aw)) begin
            w_rd_a = Dw;
        end else begin
            w_rd_a = r_mem[Aa];
        end

        if (Ab == '0) begin
            w_rd_b = '0;
        end else if (BYPASS && w_user_wr && (Ab == Aw)) begin
            w_rd_b = Dw;
        end else begin
            w_rd_b = r_mem[Ab];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            Da      <= '0;
            Db      <= '0;
            rdValid <= 1'b0;
        end else if (w_run && RdEn) begin
            Da      <= w_rd_a;
            Db      <= w_rd_b;
            rdValid <= 1'b1;
        end else begin
            rdValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_file_responder.sv
// Directed self-checking bench for register_file_responder (default 32x32 configuration).
module tb_register_file_responder;

    localparam int WIDTH     = 32;
    localparam int ADDR_BITS = 5;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 WrEn;
    logic [ADDR_BITS-1:0] Aw;
    logic [WIDTH-1:0]     Dw;
    logic                 RdEn;
    logic [ADDR_BITS-1:0] Aa;
    logic [ADDR_BITS-1:0] Ab;
    logic [WIDTH-1:0]     Da;
    logic [WIDTH-1:0]     Db;
    logic                 rdValid;
    logic                 ready;

    int n_tests = 0;
    int n_fail  = 0;

    register_file_responder #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .WrEn    (WrEn),
        .Aw      (Aw),
        .Dw      (Dw),
        .RdEn    (RdEn),
        .Aa      (Aa),
        .Ab      (Ab),
        .Da      (Da),
        .Db      (Db),
        .rdValid (rdValid),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge too.
    task automatic do_write(input logic [ADDR_BITS-1:0] addr, input logic [WIDTH-1:0] data);
        WrEn = 1'b1; Aw = addr; Dw = data;
        @(negedge clk);
        WrEn = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_BITS-1:0] a, input logic [ADDR_BITS-1:0] b);
        RdEn = 1'b1; Aa = a; Ab = b;
        @(negedge clk);
        RdEn = 1'b0;
    endtask

    // Counts falling edges with ready low, bounded; checks every sampled rdValid stays low.
    task automatic wait_ready(input string tag, input bit poke);
        int cnt = 0;
        while (!ready && cnt < 100) begin
            check({tag, "_rdvalid_init"}, 32'(rdValid), 32'd0);
            if (poke) begin
                WrEn = 1'b1; Aw = 5'd25; Dw = 32'd99;
                RdEn = 1'b1; Aa = 5'd25; Ab = 5'd25;
            end
            cnt++;
            @(negedge clk);
        end
        WrEn = 1'b0; RdEn = 1'b0;
        check({tag, "_init_cycles"}, 32'(cnt), 32'd31);
    endtask

    initial begin
        reset = 1'b1; WrEn = 1'b0; Aw = '0; Dw = '0; RdEn = 1'b0; Aa = '0; Ab = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // T1: reset state, sweep length, all registers zero
        check("rst_ready",   32'(ready),   32'd0);
        check("rst_rdvalid", 32'(rdValid), 32'd0);
        check("rst_da",      Da,           32'd0);
        check("rst_db",      Db,           32'd0);
        wait_ready("t1", 1'b0);
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            check("t1_da", Da, 32'd0);
            check("t1_db", Db, 32'd0);
            check("t1_rdvalid", 32'(rdValid), 32'd1);
        end

        // T2: write then read, valid pulse is one cycle, data holds
        do_write(5'd4, 32'd69);
        do_read(5'd4, 5'd4);
        check("t2_da", Da, 32'd69);
        check("t2_db", Db, 32'd69);
        check("t2_rdvalid", 32'(rdValid), 32'd1);
        @(negedge clk);
        check("t2_rdvalid_drop", 32'(rdValid), 32'd0);
        check("t2_da_hold", Da, 32'd69);

        // T3: write to register 0 is dropped
        do_write(5'd0, 32'd69);
        do_read(5'd0, 5'd0);
        check("t3_da", Da, 32'd0);
        check("t3_db", Db, 32'd0);

        // T4: WrEn low leaves storage alone
        do_write(5'd25, 32'd420);
        Aw = 5'd25; Dw = 32'd42;
        @(negedge clk);
        do_read(5'd4, 5'd25);
        check("t4_da", Da, 32'd69);
        check("t4_db", Db, 32'd420);

        // T5: same-cycle write and read to one address
        do_write(5'd9, 32'd3);
        WrEn = 1'b1; Aw = 5'd9; Dw = 32'd7;
        do_read(5'd9, 5'd4);
        WrEn = 1'b0;
        check("t5_da_same_cycle", Da, BYPASS ? 32'd7 : 32'd3);
        check("t5_db_other", Db, 32'd69);
        do_read(5'd9, 5'd9);
        check("t5_da_next", Da, 32'd7);
        WrEn = 1'b1; Aw = 5'd4; Dw = 32'd11;
        do_read(5'd9, 5'd4);
        WrEn = 1'b0;
        check("t5_db_same_cycle", Db, BYPASS ? 32'd11 : 32'd69);
        WrEn = 1'b1; Aw = 5'd0; Dw = 32'd5;
        do_read(5'd0, 5'd0);
        WrEn = 1'b0;
        check("t5_a0_no_fwd", Da, 32'd0);

        // T6: reset with a read in flight, writes ignored during INIT, storage cleared
        RdEn = 1'b1; Aa = 5'd25; Ab = 5'd25; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; RdEn = 1'b0;
        check("t6_rdvalid", 32'(rdValid), 32'd0);
        check("t6_da", Da, 32'd0);
        check("t6_ready", 32'(ready), 32'd0);
        wait_ready("t6", 1'b1);
        do_read(5'd4, 5'd25);
        check("t6_da_cleared", Da, 32'd0);
        check("t6_db_cleared", Db, 32'd0);
        check("t6_rdvalid_run", 32'(rdValid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
